// File: rtl/sine_cos_pkg.sv
// Shared definitions for the quadrature NCO: quadrant encoding, pipeline
// latency and the quarter-wave table generator.
package sine_cos_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    localparam int  NCO_LAT = 3;
    localparam real PI      = 3.14159265358979323846;

    // Half-sample offset makes the quarter table fold exactly into the other three quadrants.
    function automatic int qlut_value(int k, int addr_w, int out_w);
        real amp;
        real x;
        amp = real'((1 << (out_w - 1)) - 1);
        x   = amp * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(1 << addr_w));
        return $rtoi(x + 0.5);
    endfunction

endpackage

// File: rtl/sine_cos_qlut.sv
// Quarter-wave sine magnitude ROM with two independent registered read ports.
module sine_cos_qlut
    import sine_cos_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [OUT_W-1:0]  data_a,
    output logic [OUT_W-1:0]  data_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [OUT_W-1:0] rom [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign rom[gi] = OUT_W'(qlut_value(gi, ADDR_W, OUT_W));
        end
    endgenerate

    always_ff @(posedge clk) begin
        data_a <= rom[addr_a];
        data_b <= rom[addr_b];
    end

endmodule

// File: rtl/sine_cos_nco.sv
// Phase-accumulator NCO producing quadrature sine/cos in two's-complement and
// offset-binary form, three register stages from en to valid.
module sine_cos_nco
    import sine_cos_pkg::*;
#(
    parameter int                 PHASE_W  = 24,
    parameter int                 ADDR_W   = 8,
    parameter int                 OUT_W    = 8,
    parameter logic [PHASE_W-1:0] FTW_INIT = PHASE_W'(1) << (PHASE_W - ADDR_W - 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               sync_clr,
    input  logic               ftw_load,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic [PHASE_W-1:0] poff,
    output logic [OUT_W-1:0]   sine,
    output logic [OUT_W-1:0]   cos,
    output logic [OUT_W-1:0]   sine_u,
    output logic [OUT_W-1:0]   cos_u,
    output logic               valid,
    output logic               wrap
);

    localparam int FRAC_W = PHASE_W - ADDR_W - 2;

    logic [PHASE_W-1:0] acc_reg, ftw_reg;
    logic               carry_pend_reg;
    logic [PHASE_W:0]   acc_sum;
    logic [PHASE_W-1:0] phase;
    logic [ADDR_W+1:0]  phase_top;

    logic               s1_valid_reg, s1_wrap_reg;
    quad_t              s1_q_reg;
    logic [ADDR_W-1:0]  s1_i_reg;
    logic               s2_valid_reg, s2_wrap_reg;
    quad_t              s2_q_reg;
    logic [OUT_W-1:0]   lut_a, lut_b;
    logic [OUT_W-1:0]   sine_next, cos_next;
    logic [OUT_W-1:0]   sine_reg, cos_reg;
    logic               valid_reg, wrap_reg;

    assign acc_sum   = {1'b0, acc_reg} + {1'b0, ftw_reg};
    assign phase     = acc_reg + poff;
    assign phase_top = (ADDR_W + 2)'(phase >> FRAC_W);

    // A carry is remembered until the next issued sample so that sample carries the wrap flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_reg        <= '0;
            ftw_reg        <= FTW_INIT;
            carry_pend_reg <= 1'b0;
        end else begin
            if (ftw_load)
                ftw_reg <= ftw_in;
            if (sync_clr) begin
                acc_reg        <= '0;
                carry_pend_reg <= 1'b0;
            end else if (en) begin
                acc_reg        <= acc_sum[PHASE_W-1:0];
                carry_pend_reg <= acc_sum[PHASE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_wrap_reg  <= 1'b0;
            s1_q_reg     <= Q0;
            s1_i_reg     <= '0;
            s2_valid_reg <= 1'b0;
            s2_wrap_reg  <= 1'b0;
            s2_q_reg     <= Q0;
        end else begin
            s1_valid_reg <= en;
            s1_wrap_reg  <= en & carry_pend_reg;
            s1_q_reg     <= quad_t'(phase_top[ADDR_W+1 -: 2]);
            s1_i_reg     <= phase_top[ADDR_W-1:0];
            s2_valid_reg <= s1_valid_reg;
            s2_wrap_reg  <= s1_wrap_reg;
            s2_q_reg     <= s1_q_reg;
        end
    end

    // Port b reads the mirrored index N-1-i, which is simply the bitwise inverse.
    sine_cos_qlut #(
        .ADDR_W (ADDR_W),
        .OUT_W  (OUT_W)
    ) u_qlut (
        .clk    (clk),
        .addr_a (s1_i_reg),
        .addr_b (~s1_i_reg),
        .data_a (lut_a),
        .data_b (lut_b)
    );

    always_comb begin
        sine_next = lut_a;
        cos_next  = lut_b;
        case (s2_q_reg)
            Q1: begin
                sine_next = lut_b;
                cos_next  = -lut_a;
            end
            Q2: begin
                sine_next = -lut_a;
                cos_next  = -lut_b;
            end
            Q3: begin
                sine_next = -lut_b;
                cos_next  = lut_a;
            end
            default: begin
                sine_next = lut_a;
                cos_next  = lut_b;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sine_reg  <= '0;
            cos_reg   <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            valid_reg <= s2_valid_reg;
            wrap_reg  <= s2_valid_reg & s2_wrap_reg;
            if (s2_valid_reg) begin
                sine_reg <= sine_next;
                cos_reg  <= cos_next;
            end
        end
    end

    assign sine   = sine_reg;
    assign cos    = cos_reg;
    assign sine_u = {~sine_reg[OUT_W-1], sine_reg[OUT_W-2:0]};
    assign cos_u  = {~cos_reg[OUT_W-1], cos_reg[OUT_W-2:0]};
    assign valid  = valid_reg;
    assign wrap   = wrap_reg;

endmodule

// File: tb/tb_sine_cos_nco.sv
// Scoreboard bench for sine_cos_nco: stimulus pushes expected samples computed
// from direct trigonometry, a negedge monitor pops and compares on valid.
module tb_sine_cos_nco;
    import sine_cos_pkg::*;

    localparam int          AMP     = 127;
    localparam int          PERIOD  = 1024;
    localparam int          FRAC_W  = 14;
    localparam logic [23:0] FTW_DEF = 24'h004000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0, sync_clr = 1'b0, ftw_load = 1'b0;
    logic [23:0] ftw_in = '0, poff = '0;
    logic [7:0]  sine, cos, sine_u, cos_u;
    logic        valid, wrap;

    typedef struct {
        int s;
        int c;
        int w;
        int cyc;
        int r1;
        int pidx;
        bit zero;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          n_vec = 0, n_bad = 0, cyc = 0;
    logic [23:0] m_acc, m_ftw;
    bit          m_pend;
    logic [7:0]  cos0 [PERIOD];
    int          last_s = 0, last_c = 0, ms, mc, mag;
    logic        reset_prev = 1'b0;

    sine_cos_nco dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync_clr (sync_clr),
        .ftw_load (ftw_load),
        .ftw_in   (ftw_in),
        .poff     (poff),
        .sine     (sine),
        .cos      (cos),
        .sine_u   (sine_u),
        .cos_u    (cos_u),
        .valid    (valid),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int rnd(real r);
        if (r >= 0.0)
            return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    task automatic drive(bit e, bit clr, bit ld, logic [23:0] fw, logic [23:0] po,
                         int r1, int pidx, bit zero);
        exp_t        x;
        logic [23:0] p;
        logic [24:0] sum;
        int          m;
        real         ang;
        en       = e;
        sync_clr = clr;
        ftw_load = ld;
        ftw_in   = fw;
        poff     = po;
        if (e) begin
            p      = m_acc + po;
            m      = int'(p >> FRAC_W);
            ang    = 2.0 * PI * (real'(m) + 0.5) / real'(PERIOD);
            x.s    = rnd(real'(AMP) * $sin(ang));
            x.c    = rnd(real'(AMP) * $cos(ang));
            x.w    = int'(m_pend);
            x.cyc  = cyc;
            x.r1   = r1;
            x.pidx = pidx;
            x.zero = zero;
            sb.push_back(x);
        end
        sum = {1'b0, m_acc} + {1'b0, m_ftw};
        if (clr) begin
            m_acc  = '0;
            m_pend = 1'b0;
        end else if (e) begin
            m_acc  = sum[23:0];
            m_pend = sum[24];
        end
        if (ld)
            m_ftw = fw;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_wrap"}, int'(wrap), 0);
        chk({tag, "_sine"}, int'(sine), 0);
        chk({tag, "_cos"}, int'(cos), 0);
        chk({tag, "_sine_u"}, int'(sine_u), 128);
        chk({tag, "_cos_u"}, int'(cos_u), 128);
    endtask

    always @(negedge clk) begin
        if (reset && reset_prev) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    me = sb.pop_front();
                    ms = int'($signed(sine));
                    mc = int'($signed(cos));
                    chk("sine", ms, me.s);
                    chk("cos", mc, me.c);
                    chk("sine_u", int'(sine_u), (me.s + 128) & 255);
                    chk("cos_u", int'(cos_u), (me.c + 128) & 255);
                    chk("wrap", int'(wrap), me.w);
                    chk("latency", cyc - me.cyc, NCO_LAT);
                    mag = ms * ms + mc * mc - AMP * AMP;
                    if (mag < 0)
                        mag = -mag;
                    chk("mag_within_tol", int'(mag <= 4 * AMP), 1);
                    if (me.r1 >= 0 && me.r1 < PERIOD)
                        cos0[me.r1] = cos;
                    case (me.r1)
                        0: begin
                            chk("s0_sine", int'(sine), 0);
                            chk("s0_cos", int'(cos), 127);
                            chk("s0_sine_u", int'(sine_u), 128);
                            chk("s0_cos_u", int'(cos_u), 255);
                        end
                        256: begin
                            chk("s256_sine", int'(sine), 127);
                            chk("s256_cos", int'(cos), 0);
                        end
                        768: begin
                            chk("s768_sine", int'(sine), 8'h81);
                            chk("s768_sine_u", int'(sine_u), 8'h01);
                        end
                        1024: begin
                            chk("s1024_wrap", int'(wrap), 1);
                            chk("s1024_sine", int'(sine), 0);
                            chk("s1024_cos", int'(cos), 127);
                        end
                        default: ;
                    endcase
                    if (me.pidx >= 0)
                        chk("poff_quarter", int'(sine), int'(cos0[me.pidx]));
                    if (me.zero) begin
                        chk("phase0_sine", int'(sine), 0);
                        chk("phase0_cos", int'(cos), 127);
                    end
                end
            end else begin
                chk("hold_sine", int'(sine), last_s);
                chk("hold_cos", int'(cos), last_c);
                chk("wrap_idle", int'(wrap), 0);
            end
        end
        last_s     = int'(sine);
        last_c     = int'(cos);
        reset_prev = reset;
    end

    initial begin
        m_acc  = '0;
        m_ftw  = FTW_DEF;
        m_pend = 1'b0;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset = 1'b1;

        // One full cycle plus a few samples at the default tuning word.
        for (int k = 0; k < PERIOD + 6; k++)
            drive(1, 0, 0, '0, '0, k, -1, 0);

        // Two ROM steps per sample, then a frozen oscillator.
        drive(1, 0, 1, 24'h008000, '0, -1, -1, 0);
        for (int k = 0; k < 600; k++)
            drive(1, 0, 0, '0, '0, -1, -1, 0);
        drive(1, 0, 1, 24'h000000, '0, -1, -1, 0);
        for (int k = 0; k < 20; k++)
            drive(1, 0, 0, '0, '0, -1, -1, 0);

        // Restore the default rate from phase 0 and run a quarter-cycle offset.
        drive(0, 1, 1, FTW_DEF, '0, -1, -1, 0);
        for (int k = 0; k < PERIOD; k++)
            drive(1, 0, 0, '0, 24'h400000, -1, k, 0);

        for (int k = 0; k < 40; k++)
            drive(k % 2 == 0, 0, 0, '0, '0, -1, -1, 0);

        // Clear with en high: that sample uses the old phase, the next starts at 0.
        for (int k = 0; k < 5; k++)
            drive(1, 0, 0, '0, '0, -1, -1, 0);
        drive(1, 1, 0, '0, '0, -1, -1, 0);
        drive(1, 0, 0, '0, '0, -1, -1, 1);
        for (int k = 0; k < 5; k++)
            drive(1, 0, 0, '0, '0, -1, -1, 0);

        // Reset while samples are in flight.
        en       = 1'b1;
        sync_clr = 1'b0;
        ftw_load = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("midrun_reset");
        sb.delete();
        m_acc  = '0;
        m_ftw  = FTW_DEF;
        m_pend = 1'b0;
        en     = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("midrun_flush");
        reset = 1'b1;
        drive(1, 0, 0, '0, '0, -1, -1, 1);
        for (int k = 0; k < 4; k++)
            drive(1, 0, 0, '0, '0, -1, -1, 0);

        for (int k = 0; k < 10 && sb.size() != 0; k++)
            drive(0, 0, 0, '0, '0, -1, -1, 0);
        chk("scoreboard_drained", sb.size(), 0);
        drive(0, 0, 0, '0, '0, -1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
